// File: rtl/buyruk_onbellegi_pkg.sv
// ============================================================================
// Module      : buyruk_onbellegi_pkg
// Description : Shared constants, FSM encoding and address-field helpers for
//               the direct-mapped instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package buyruk_onbellegi_pkg;

    localparam int unsigned c_SATIR_SAYISI = 64;
    localparam int unsigned c_SATIR_KELIME = 4;

    localparam int unsigned OFSET_BIT  = $clog2(c_SATIR_KELIME);
    localparam int unsigned INDIS_BIT  = $clog2(c_SATIR_SAYISI);
    localparam int unsigned ETIKET_BIT = 32 - 2 - OFSET_BIT - INDIS_BIT;

    typedef enum logic [1:0] {
        BOSTA  = 2'd0,
        DOLDUR = 2'd1,
        CEVAP  = 2'd2
    } durum_t;

    // Field helpers return right-justified values; callers size-cast to their widths.
    function automatic logic [31:0] ofset_al(input logic [31:0] ps, input int unsigned ofset_bit);
        return (ps >> 2) & ((32'd1 << ofset_bit) - 32'd1);
    endfunction

    function automatic logic [31:0] indis_al(input logic [31:0] ps, input int unsigned ofset_bit,
                                             input int unsigned indis_bit);
        return (ps >> (2 + ofset_bit)) & ((32'd1 << indis_bit) - 32'd1);
    endfunction

    function automatic logic [31:0] etiket_al(input logic [31:0] ps, input int unsigned ofset_bit,
                                              input int unsigned indis_bit);
        return ps >> (2 + ofset_bit + indis_bit);
    endfunction

endpackage

`default_nettype wire

// File: rtl/buyruk_onbellegi_if.sv
// ============================================================================
// Module      : buyruk_onbellegi_if
// Description : Fetch-side and memory-side signals of the instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface buyruk_onbellegi_if;
    logic        getir_istek_i;
    logic [31:0] getir_ps_i;
    logic        getir_gecerli_o;
    logic [31:0] getir_deger_o;
    logic        getir_hazir_o;
    logic        getir_bosalt_i;
    logic        ana_bellek_istek_o;
    logic [31:0] ana_bellek_adres_o;
    logic        ana_bellek_gecerli_i;
    logic [31:0] ana_bellek_veri_i;

    // slave: the cache itself
    modport slave (
        input  getir_istek_i, getir_ps_i, getir_bosalt_i,
        input  ana_bellek_gecerli_i, ana_bellek_veri_i,
        output getir_gecerli_o, getir_deger_o, getir_hazir_o,
        output ana_bellek_istek_o, ana_bellek_adres_o
    );

    // master: fetch stage plus main memory
    modport master (
        output getir_istek_i, getir_ps_i, getir_bosalt_i,
        output ana_bellek_gecerli_i, ana_bellek_veri_i,
        input  getir_gecerli_o, getir_deger_o, getir_hazir_o,
        input  ana_bellek_istek_o, ana_bellek_adres_o
    );
endinterface

`default_nettype wire

// File: rtl/buyruk_onbellegi_veri_dizisi.sv
// ============================================================================
// Module      : onbellek_veri_dizisi
// Description : Word storage, one synchronous write port and one
//               combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onbellek_veri_dizisi #(
    parameter int unsigned DERINLIK = 256,
    parameter int unsigned ADRES_W  = 8
) (
    input  wire logic               clk_i,
    input  wire logic               i_yaz,
    input  wire logic [ADRES_W-1:0] i_yaz_adres,
    input  wire logic [31:0]        i_yaz_veri,
    input  wire logic [ADRES_W-1:0] i_oku_adres,
    output logic      [31:0]        o_oku_veri
);

    logic [31:0] r_bellek [DERINLIK];

    always_ff @(posedge clk_i) begin
        if (i_yaz) begin
            r_bellek[i_yaz_adres] <= i_yaz_veri;
        end
    end

    assign o_oku_veri = r_bellek[i_oku_adres];

endmodule

`default_nettype wire

// File: rtl/buyruk_onbellegi.sv
// ============================================================================
// Module      : buyruk_onbellegi
// Description : Direct-mapped read-only instruction cache with word-serial
//               refill and single-cycle invalidate-all.
//               ICACHE_SAYAC_EN adds hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module buyruk_onbellegi
    import buyruk_onbellegi_pkg::*;
#(
    parameter int unsigned SATIR_SAYISI = c_SATIR_SAYISI,
    parameter int unsigned SATIR_KELIME = c_SATIR_KELIME
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    buyruk_onbellegi_if.slave bag
`ifdef ICACHE_SAYAC_EN
    ,
    output logic [31:0]       isabet_sayisi_o,
    output logic [31:0]       iska_sayisi_o
`endif
);

    localparam int unsigned c_OFSET_W  = $clog2(SATIR_KELIME);
    localparam int unsigned c_INDIS_W  = $clog2(SATIR_SAYISI);
    localparam int unsigned c_ETIKET_W = 32 - 2 - c_OFSET_W - c_INDIS_W;
    localparam int unsigned c_ADRES_W  = c_INDIS_W + c_OFSET_W;

    durum_t                  r_durum, w_sonraki;
    logic [31:0]             r_miss_ps;
    logic [c_OFSET_W-1:0]    r_k;
    logic                    r_iptal;
    logic                    r_isabet;
    logic [31:0]             r_son_deger;
    logic [c_ADRES_W-1:0]    r_oku_adres;
    logic [SATIR_SAYISI-1:0] r_gecerli;
    logic [c_ETIKET_W-1:0]   r_etiket [SATIR_SAYISI];

    logic [c_OFSET_W-1:0]    w_istek_ofset, w_miss_ofset;
    logic [c_INDIS_W-1:0]    w_istek_indis, w_miss_indis;
    logic [c_ETIKET_W-1:0]   w_istek_etiket, w_miss_etiket;
    logic                    w_kabul, w_isabet, w_vurus, w_son_vurus, w_gecerli;
    logic [c_ADRES_W-1:0]    w_oku_adres;
    logic [31:0]             w_oku_veri;

    assign w_istek_ofset  = c_OFSET_W'(ofset_al(bag.getir_ps_i, c_OFSET_W));
    assign w_istek_indis  = c_INDIS_W'(indis_al(bag.getir_ps_i, c_OFSET_W, c_INDIS_W));
    assign w_istek_etiket = c_ETIKET_W'(etiket_al(bag.getir_ps_i, c_OFSET_W, c_INDIS_W));
    assign w_miss_ofset   = c_OFSET_W'(ofset_al(r_miss_ps, c_OFSET_W));
    assign w_miss_indis   = c_INDIS_W'(indis_al(r_miss_ps, c_OFSET_W, c_INDIS_W));
    assign w_miss_etiket  = c_ETIKET_W'(etiket_al(r_miss_ps, c_OFSET_W, c_INDIS_W));

    assign w_kabul     = (r_durum == BOSTA) & bag.getir_istek_i & ~bag.getir_bosalt_i;
    assign w_isabet    = r_gecerli[w_istek_indis] & (r_etiket[w_istek_indis] == w_istek_etiket);
    assign w_vurus     = (r_durum == DOLDUR) & bag.ana_bellek_gecerli_i;
    assign w_son_vurus = w_vurus & (r_k == c_OFSET_W'(SATIR_KELIME - 1));
    assign w_gecerli   = r_isabet | (r_durum == CEVAP);

    // CEVAP reads the refilled word directly; hits use the index registered at accept.
    assign w_oku_adres = (r_durum == CEVAP) ? {w_miss_indis, w_miss_ofset} : r_oku_adres;

    onbellek_veri_dizisi #(
        .DERINLIK (SATIR_SAYISI * SATIR_KELIME),
        .ADRES_W  (c_ADRES_W)
    ) u_veri (
        .clk_i       (clk_i),
        .i_yaz       (w_vurus),
        .i_yaz_adres ({w_miss_indis, r_k}),
        .i_yaz_veri  (bag.ana_bellek_veri_i),
        .i_oku_adres (w_oku_adres),
        .o_oku_veri  (w_oku_veri)
    );

    always_comb begin
        w_sonraki                = r_durum;
        bag.getir_hazir_o        = 1'b0;
        bag.ana_bellek_istek_o   = 1'b0;
        bag.ana_bellek_adres_o   = 32'd0;
        bag.getir_gecerli_o      = w_gecerli;
        bag.getir_deger_o        = w_gecerli ? w_oku_veri : r_son_deger;
        case (r_durum)
            BOSTA: begin
                bag.getir_hazir_o = 1'b1;
                if (w_kabul && !w_isabet) begin
                    w_sonraki = DOLDUR;
                end
            end
            DOLDUR: begin
                bag.ana_bellek_istek_o = 1'b1;
                bag.ana_bellek_adres_o = {r_miss_ps[31:c_OFSET_W+2], r_k, 2'b00};
                if (w_son_vurus) begin
                    // A flush seen at any point of the burst suppresses validation and the reply.
                    w_sonraki = (r_iptal || bag.getir_bosalt_i) ? BOSTA : CEVAP;
                end
            end
            CEVAP:   w_sonraki = BOSTA;
            default: w_sonraki = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_durum     <= BOSTA;
            r_miss_ps   <= 32'd0;
            r_k         <= '0;
            r_iptal     <= 1'b0;
            r_isabet    <= 1'b0;
            r_son_deger <= 32'd0;
            r_oku_adres <= '0;
        end else begin
            r_durum  <= w_sonraki;
            r_isabet <= w_kabul & w_isabet;
            if (w_kabul) begin
                r_oku_adres <= {w_istek_indis, w_istek_ofset};
            end
            if (w_kabul && !w_isabet) begin
                r_miss_ps <= bag.getir_ps_i;
                r_k       <= '0;
            end else if (w_vurus) begin
                r_k <= r_k + 1'b1;
            end
            if (w_sonraki == BOSTA) begin
                r_iptal <= 1'b0;
            end else if (r_durum == DOLDUR && bag.getir_bosalt_i) begin
                r_iptal <= 1'b1;
            end
            if (w_gecerli) begin
                r_son_deger <= w_oku_veri;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_gecerli <= '0;
        end else if (bag.getir_bosalt_i) begin
            r_gecerli <= '0;
        end else if (w_son_vurus && !r_iptal) begin
            r_gecerli[w_miss_indis] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_son_vurus) begin
            r_etiket[w_miss_indis] <= w_miss_etiket;
        end
    end

`ifdef ICACHE_SAYAC_EN
    logic [31:0] r_isabet_sayisi, r_iska_sayisi;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_isabet_sayisi <= 32'd0;
            r_iska_sayisi   <= 32'd0;
        end else begin
            if (w_kabul && w_isabet) begin
                r_isabet_sayisi <= r_isabet_sayisi + 32'd1;
            end
            if (w_kabul && !w_isabet) begin
                r_iska_sayisi <= r_iska_sayisi + 32'd1;
            end
        end
    end

    assign isabet_sayisi_o = r_isabet_sayisi;
    assign iska_sayisi_o   = r_iska_sayisi;
`endif

endmodule

`default_nettype wire

// File: tb/tb_buyruk_onbellegi.sv
// ============================================================================
// Module      : tb_buyruk_onbellegi
// Description : Directed scoreboard bench for the instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_buyruk_onbellegi;

    logic clk;
    logic rst;
    int   n_vektor = 0;
    int   n_hata   = 0;
    int   n_yanit  = 0;
    logic [31:0] beklenen_q [$];

    buyruk_onbellegi_if bag ();

`ifdef ICACHE_SAYAC_EN
    logic [31:0] isabet_sayisi, iska_sayisi;
`endif

    buyruk_onbellegi dut (
        .clk_i (clk),
        .rst_i (rst),
        .bag   (bag)
`ifdef ICACHE_SAYAC_EN
        ,
        .isabet_sayisi_o (isabet_sayisi),
        .iska_sayisi_o   (iska_sayisi)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: 0x100..0x10C hold 0xA0..0xA3, other lines stay distinct.
    function automatic logic [31:0] bellek(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:4], 4'h0} ^ 32'h0000_01A0;
        return b + {30'd0, a[3:2]};
    endfunction

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        n_vektor++;
        assert (gozlenen === beklenen) else begin
            n_hata++;
            $error("FAIL %s: observed=%h expected=%h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic istek(input logic [31:0] ps);
        bag.getir_istek_i = 1'b1;
        bag.getir_ps_i    = ps;
        tick();
        bag.getir_istek_i = 1'b0;
    endtask

    // Serve one refill burst; a stall is inserted before beat 2.
    task automatic hizmet(input logic [31:0] taban, input int bosalt_vurus);
        int bekle;
        bekle = 0;
        while (bag.ana_bellek_istek_o !== 1'b1 && bekle < 16) begin
            tick();
            bekle++;
        end
        kontrol("refill_request", 32'(bag.ana_bellek_istek_o), 32'd1);
        if (bag.ana_bellek_istek_o !== 1'b1) return;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                tick();
                kontrol("request_held", 32'(bag.ana_bellek_istek_o), 32'd1);
            end
            kontrol("beat_addr", bag.ana_bellek_adres_o, taban + 32'(4 * k));
            kontrol("ready_in_refill", 32'(bag.getir_hazir_o), 32'd0);
            bag.ana_bellek_gecerli_i = 1'b1;
            bag.ana_bellek_veri_i    = bellek(taban + 32'(4 * k));
            bag.getir_bosalt_i       = (k == bosalt_vurus);
            tick();
            bag.ana_bellek_gecerli_i = 1'b0;
            bag.getir_bosalt_i       = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bag.getir_gecerli_o === 1'b1) begin
            n_yanit++;
            if (beklenen_q.size() == 0) begin
                kontrol("unexpected_response", 32'(beklenen_q.size()), 32'd1);
            end else begin
                kontrol("response_word", bag.getir_deger_o, beklenen_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int yanit_once;
        rst = 1'b1;
        bag.getir_istek_i        = 1'b0;
        bag.getir_ps_i           = 32'd0;
        bag.getir_bosalt_i       = 1'b0;
        bag.ana_bellek_gecerli_i = 1'b0;
        bag.ana_bellek_veri_i    = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        kontrol("rst_valid", 32'(bag.getir_gecerli_o), 32'd0);
        kontrol("rst_word", bag.getir_deger_o, 32'd0);
        kontrol("rst_mem_req", 32'(bag.ana_bellek_istek_o), 32'd0);
        kontrol("rst_mem_addr", bag.ana_bellek_adres_o, 32'd0);
        kontrol("rst_ready", 32'(bag.getir_hazir_o), 32'd1);

        // Cold miss
        yanit_once = n_yanit;
        beklenen_q.push_back(32'h0000_00A0);
        istek(32'h0000_0100);
        hizmet(32'h0000_0100, -1);
        tick();
        kontrol("cold_one_pulse", 32'(n_yanit - yanit_once), 32'd1);
        kontrol("ready_after_fill", 32'(bag.getir_hazir_o), 32'd1);

        // Hit streaming
        bag.getir_istek_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            bag.getir_ps_i = 32'h0000_0100 + 32'(4 * i);
            beklenen_q.push_back(bellek(bag.getir_ps_i));
            tick();
            kontrol("hit_valid", 32'(bag.getir_gecerli_o), 32'd1);
            kontrol("hit_no_mem", 32'(bag.ana_bellek_istek_o), 32'd0);
        end
        bag.getir_istek_i = 1'b0;
        tick();
        kontrol("stream_drained", 32'(beklenen_q.size()), 32'd0);
        kontrol("word_hold", bag.getir_deger_o, 32'h0000_00A3);

        // Conflict eviction
        beklenen_q.push_back(bellek(32'h0000_0508));
        istek(32'h0000_0508);
        hizmet(32'h0000_0500, -1);
        tick();
        beklenen_q.push_back(32'h0000_00A0);
        istek(32'h0000_0100);
        kontrol("evicted_miss", 32'(bag.ana_bellek_istek_o), 32'd1);
        hizmet(32'h0000_0100, -1);
        tick();

        // Flush during beat 1
        yanit_once = n_yanit;
        istek(32'h0000_0204);
        hizmet(32'h0000_0200, 1);
        kontrol("flush_ready", 32'(bag.getir_hazir_o), 32'd1);
        tick();
        kontrol("flush_no_pulse", 32'(n_yanit - yanit_once), 32'd0);
        beklenen_q.push_back(bellek(32'h0000_0204));
        istek(32'h0000_0204);
        kontrol("flush_re_miss", 32'(bag.ana_bellek_istek_o), 32'd1);
        hizmet(32'h0000_0200, -1);
        tick();

        // Flush with simultaneous request on a cached address
        yanit_once = n_yanit;
        bag.getir_bosalt_i = 1'b1;
        istek(32'h0000_0204);
        bag.getir_bosalt_i = 1'b0;
        kontrol("flushreq_no_mem", 32'(bag.ana_bellek_istek_o), 32'd0);
        tick();
        kontrol("flushreq_no_pulse", 32'(n_yanit - yanit_once), 32'd0);
        beklenen_q.push_back(bellek(32'h0000_020C));
        istek(32'h0000_020C);
        kontrol("flushreq_miss", 32'(bag.ana_bellek_istek_o), 32'd1);
        hizmet(32'h0000_0200, -1);
        // Flush in CEVAP: reply still delivered, line dropped
        bag.getir_bosalt_i = 1'b1;
        tick();
        bag.getir_bosalt_i = 1'b0;
        beklenen_q.push_back(bellek(32'h0000_0200));
        istek(32'h0000_0200);
        kontrol("cevap_flush_miss", 32'(bag.ana_bellek_istek_o), 32'd1);
        hizmet(32'h0000_0200, -1);
        tick();

        // Reset in the middle of a refill
        yanit_once = n_yanit;
        istek(32'h0000_0300);
        bag.ana_bellek_gecerli_i = 1'b1;
        bag.ana_bellek_veri_i    = bellek(32'h0000_0300);
        tick();
        bag.ana_bellek_gecerli_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        kontrol("midrst_mem_req", 32'(bag.ana_bellek_istek_o), 32'd0);
        kontrol("midrst_ready", 32'(bag.getir_hazir_o), 32'd1);
        bag.ana_bellek_gecerli_i = 1'b1;
        bag.ana_bellek_veri_i    = 32'hDEAD_BEEF;
        tick();
        bag.ana_bellek_gecerli_i = 1'b0;
        tick();
        kontrol("midrst_no_pulse", 32'(n_yanit - yanit_once), 32'd0);
        beklenen_q.push_back(bellek(32'h0000_0300));
        istek(32'h0000_0300);
        hizmet(32'h0000_0300, -1);
        tick();

`ifdef ICACHE_SAYAC_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        kontrol("cnt_rst_hit", isabet_sayisi, 32'd0);
        kontrol("cnt_rst_miss", iska_sayisi, 32'd0);
        beklenen_q.push_back(bellek(32'h0000_0100));
        istek(32'h0000_0100);
        hizmet(32'h0000_0100, -1);
        tick();
        for (int i = 0; i < 3; i++) begin
            beklenen_q.push_back(bellek(32'h0000_0100 + 32'(4 * i)));
            istek(32'h0000_0100 + 32'(4 * i));
        end
        beklenen_q.push_back(bellek(32'h0000_0600));
        istek(32'h0000_0600);
        hizmet(32'h0000_0600, -1);
        tick();
        kontrol("cnt_hits", isabet_sayisi, 32'd3);
        kontrol("cnt_misses", iska_sayisi, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        kontrol("cnt_clr_hit", isabet_sayisi, 32'd0);
        kontrol("cnt_clr_miss", iska_sayisi, 32'd0);
`endif

        tick();
        kontrol("queue_empty", 32'(beklenen_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vektor, n_hata);
        $finish;
    end

endmodule

`default_nettype wire
